// File: rtl/fetch_unit.sv
// PC register and fetch stage: drives instrmem, queues {pc, instr} toward decode, applies branch redirects.
// Optional performance counters (fetch_cnt, flush_cnt) are built when FETCH_PERF_EN is defined.
module fetch_unit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    QDEPTH       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] instr_in,
    input  logic                  stall,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    input  logic                  PCsrc,
    input  logic [DATA_WIDTH-1:0] ImmOp
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           fetch_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

    logic [DATA_WIDTH-1:0] q_pc    [QDEPTH];
    logic [DATA_WIDTH-1:0] q_instr [QDEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;

    logic                  full;
    logic                  accept;
    logic                  redirect;
    logic                  push;
    logic signed [DATA_WIDTH-1:0] imm_s;
    logic signed [DATA_WIDTH-1:0] target_s;

    assign full      = (count == FULL_CNT);
    assign valid_out = (count != '0);
    assign accept    = valid_out & ready_in;
    assign redirect  = accept & PCsrc;
    assign push      = ~stall & ~redirect & (~full | accept);

    // Branch target is relative to the instruction being accepted, wrapping modulo 2^DATA_WIDTH.
    assign imm_s    = $signed(ImmOp);
    assign target_s = $signed(pc_out) + imm_s;

    assign instr  = q_instr[head];
    assign pc_out = q_pc[head];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc    <= RESET_VECTOR;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else if (redirect) begin
            pc    <= $unsigned(target_s);
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                q_pc[tail]    <= pc;
                q_instr[tail] <= instr_in;
                tail          <= tail + PTR_W'(1);
                pc            <= pc + DATA_WIDTH'(4);
            end
            if (accept) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(accept);
        end
    end

`ifdef FETCH_PERF_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // The accepted head is consumed, not discarded, so a flush drops count-1 entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (push) begin
                fetch_cnt <= sat_add(fetch_cnt, 32'd1);
            end
            if (redirect) begin
                flush_cnt <= sat_add(flush_cnt, 32'(count - CNT_W'(1)));
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: table-driven cycle vectors plus reset, backpressure and drain sequences.
module tb_fetch_unit;

    localparam logic [31:0] MAGIC = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc;
    logic [31:0] instr_in;
    logic        stall = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic        PCsrc = 1'b0;
    logic [31:0] ImmOp = '0;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instruction memory model: every word is a fixed function of its address.
    assign instr_in = pc ^ MAGIC;

    fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .instr_in  (instr_in),
        .stall     (stall),
        .instr     (instr),
        .pc_out    (pc_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .PCsrc     (PCsrc),
        .ImmOp     (ImmOp)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt (fetch_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        ready;
        logic        br;
        logic [31:0] imm;
        logic [31:0] epc;
        logic        ev;
        logic [31:0] epo;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    function automatic vec_t mk(logic r, logic s, logic rd, logic b, logic [31:0] imm,
                                logic [31:0] epc, logic ev, logic [31:0] epo);
        vec_t v;
        v.rst_n = r; v.stall = s; v.ready = rd; v.br = b; v.imm = imm;
        v.epc = epc; v.ev = ev; v.epo = epo;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    logic [31:0] sb [$];

    initial begin
        // rst stall ready br imm | pc valid pc_out   (outputs observed before this cycle's edge)
        tbl[0]  = mk(0, 0, 0, 0, 32'h0,         32'h0,        0, 32'h0);
        tbl[1]  = mk(1, 0, 1, 0, 32'h0,         32'h0,        0, 32'h0);
        tbl[2]  = mk(1, 0, 1, 0, 32'h0,         32'h4,        1, 32'h0);
        tbl[3]  = mk(1, 0, 1, 0, 32'h0,         32'h8,        1, 32'h4);
        tbl[4]  = mk(1, 0, 1, 0, 32'h0,         32'hC,        1, 32'h8);
        tbl[5]  = mk(1, 0, 0, 0, 32'h0,         32'h10,       1, 32'hC);
        tbl[6]  = mk(1, 0, 1, 0, 32'h0,         32'h14,       1, 32'hC);
        tbl[7]  = mk(1, 0, 1, 1, 32'hFFFF_FFF8, 32'h18,       1, 32'h10);
        tbl[8]  = mk(1, 0, 1, 0, 32'h0,         32'h8,        0, 32'h0);
        tbl[9]  = mk(1, 0, 1, 0, 32'h0,         32'hC,        1, 32'h8);
        tbl[10] = mk(1, 0, 0, 1, 32'h100,       32'h10,       1, 32'hC);
        tbl[11] = mk(1, 0, 0, 0, 32'h0,         32'h14,       1, 32'hC);
        tbl[12] = mk(1, 1, 1, 0, 32'h0,         32'h14,       1, 32'hC);
        tbl[13] = mk(1, 0, 0, 0, 32'h0,         32'h14,       1, 32'h10);
        tbl[14] = mk(0, 0, 0, 0, 32'h0,         32'h0,        0, 32'h0);
        tbl[15] = mk(1, 0, 1, 0, 32'h0,         32'h0,        0, 32'h0);
        tbl[16] = mk(1, 1, 1, 1, 32'h20,        32'h4,        1, 32'h0);
        tbl[17] = mk(1, 1, 1, 0, 32'h0,         32'h20,       0, 32'h0);
        tbl[18] = mk(1, 0, 1, 0, 32'h0,         32'h20,       0, 32'h0);
        tbl[19] = mk(1, 0, 1, 0, 32'h0,         32'h24,       1, 32'h20);
        tbl[20] = mk(0, 0, 0, 0, 32'h0,         32'h0,        0, 32'h0);
        tbl[21] = mk(1, 0, 1, 0, 32'h0,         32'h0,        0, 32'h0);
        tbl[22] = mk(1, 0, 1, 1, 32'hFFFF_FFFC, 32'h4,        1, 32'h0);
        tbl[23] = mk(1, 0, 1, 0, 32'h0,         32'hFFFF_FFFC, 0, 32'h0);
        tbl[24] = mk(1, 0, 1, 1, 32'h6,         32'h0,        1, 32'hFFFF_FFFC);
        tbl[25] = mk(1, 0, 1, 0, 32'h0,         32'h2,        0, 32'h0);
        tbl[26] = mk(1, 0, 1, 0, 32'h0,         32'h6,        1, 32'h2);

        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst      = tbl[i].rst_n;
            stall    = tbl[i].stall;
            ready_in = tbl[i].ready;
            PCsrc    = tbl[i].br;
            ImmOp    = tbl[i].imm;
            #1;
            chk("pc", i, pc, tbl[i].epc);
            chk("valid_out", i, {31'b0, valid_out}, {31'b0, tbl[i].ev});
            if (tbl[i].ev || !tbl[i].rst_n) begin
                chk("pc_out", i, pc_out, tbl[i].epo);
                chk("instr", i, instr, tbl[i].rst_n ? (tbl[i].epo ^ MAGIC) : 32'h0);
            end
`ifdef FETCH_PERF_EN
            if (i == 13) begin
                chk("fetch_cnt", i, fetch_cnt, 32'd9);
                chk("flush_cnt", i, flush_cnt, 32'd1);
            end
`endif
        end

        // Asynchronous reset mid-run once pc reaches 0x40.
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; PCsrc = 1'b0; ImmOp = '0; ready_in = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        begin
            bit hit;
            hit = 1'b0;
            for (int n = 0; n < 40 && !hit; n++) begin
                @(negedge clk);
                #1;
                if (pc == 32'h40) hit = 1'b1;
            end
            chk("reach_pc40", 100, pc, 32'h40);
        end
        #2 rst = 1'b0;
        #1;
        chk("async_rst_pc", 101, pc, 32'h0);
        chk("async_rst_valid", 101, {31'b0, valid_out}, 32'h0);
        chk("async_rst_pc_out", 101, pc_out, 32'h0);
        chk("async_rst_instr", 101, instr, 32'h0);

        // Backpressure: fill to two entries, pc stalls at 8, head held at pc 0.
        @(negedge clk);
        rst = 1'b1;
        ready_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            logic [31:0] exp_pc;
            if (k > 0) @(negedge clk);
            ready_in = 1'b0;
            #1;
            exp_pc = (k >= 2) ? 32'h8 : 32'(k * 4);
            chk("bp_pc", 200 + k, pc, exp_pc);
            chk("bp_valid", 200 + k, {31'b0, valid_out}, (k >= 1) ? 32'h1 : 32'h0);
            if (k >= 1) begin
                chk("bp_pc_out", 200 + k, pc_out, 32'h0);
                chk("bp_instr", 200 + k, instr, MAGIC);
            end
        end

        // Drain in order through the scoreboard.
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        sb.push_back(32'h8);
        sb.push_back(32'hC);
        sb.push_back(32'h10);
        @(negedge clk);
        ready_in = 1'b1;
        for (int n = 0; n < 12 && sb.size() > 0; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            if (valid_out && ready_in) begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("drain_pc_out", 300 + n, pc_out, e);
                chk("drain_instr", 300 + n, instr, e ^ MAGIC);
            end
        end
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout: %0d entries never presented, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
